clk_div_ctrl: RTL

Run-time controller and generator for a programmable even-ratio clock divider. It accepts new divide ratios over a valid/ready config port and applies them only at output period boundaries, so clk_out never glitches or produces a runt phase. It also sequences start and stop: stop always completes the current period. It sits between a register/config master and the clock consumers that previously used a fixed-ratio divider.

---
 rtl/clk_div_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable even-ratio clock divider with run/stop sequencing.
// New ratios are applied only at period boundaries or while idle.
module clk_div_ctrl #(
    parameter int CNT_W       = 6,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             run_req,
    output logic             clk_out,
    output logic             busy,
    output logic [CNT_W-1:0] div_active,
    output logic             switch_done,
    output logic             cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

    state_t           state, state_n;
    logic [CNT_W:0]   cnt, cnt_n;
    logic [CNT_W:0]   half_end, per_end;
    logic [CNT_W-1:0] pdiv, pdiv_n, div_n;
    logic             pend, pend_n;
    logic             clk_n, busy_n, sw_n, err_n;
    logic             take, bound, apply;

    assign cfg_ready = !pend;
    assign take      = cfg_valid && !pend;
    assign half_end  = {1'b0, div_active} - ONE;
    assign per_end   = {div_active, 1'b0} - ONE;
    assign bound     = (state != IDLE) && (cnt == per_end);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            clk_out     <= 1'b0;
            busy        <= 1'b0;
            div_active  <= CNT_W'(DIV_DEFAULT);
            pdiv        <= '0;
            pend        <= 1'b0;
            switch_done <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            clk_out     <= clk_n;
            busy        <= busy_n;
            div_active  <= div_n;
            pdiv        <= pdiv_n;
            pend        <= pend_n;
            switch_done <= sw_n;
            cfg_err     <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clk_n   = clk_out;
        div_n   = div_active;
        pdiv_n  = pdiv;
        pend_n  = pend;
        sw_n    = 1'b0;
        err_n   = 1'b0;
        apply   = 1'b0;

        if (take) begin
            if (cfg_div == '0) begin
                err_n = 1'b1;
            end else begin
                pend_n = 1'b1;
                pdiv_n = cfg_div;
            end
        end

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                clk_n = 1'b0;
                apply = pend;
                if (run_req) state_n = RUN;
            end
            RUN, DRAIN: begin
                cnt_n = cnt + ONE;
                if (cnt == half_end) clk_n = 1'b1;
                if (bound) begin
                    cnt_n = '0;
                    clk_n = 1'b0;
                    apply = pend;
                end
                // DRAIN only retires to IDLE once the period is complete
                if (run_req)
                    state_n = RUN;
                else if (state == DRAIN && bound)
                    state_n = IDLE;
                else
                    state_n = DRAIN;
            end
            default: state_n = IDLE;
        endcase

        // take and apply are exclusive: take needs pend low, apply needs it high
        if (apply) begin
            div_n  = pdiv;
            pend_n = 1'b0;
            sw_n   = 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

endmodule
